hazard_scoreboard: RTL

- Producer-side companion to the forwarding unit in the 5-stage ARM-subset pipeline.
- Tracks the destination register, write-back enable and load flag of each in-flight instruction in the EXE, MEM and WB slots.
- Exports those slots to the forwarding unit and raises a stall to IF/ID when a source operand cannot be covered by forwarding (load-use) or when forwarding is disabled.
- Honours memory freeze and branch flush.

---
 rtl/pipeline_pkg.sv | 21 ++
 rtl/sb_match.sv | 14 +
 rtl/hazard_scoreboard.sv | 95 +++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: scoreboard slot entry, bubble constant and forwarding selects.
// Used by the hazard scoreboard and the forwarding unit.
package pipeline_pkg;

  localparam int REG_ADDR_W_DEFAULT = 4;

  typedef struct packed {
    logic [REG_ADDR_W_DEFAULT-1:0] dest;
    logic                          wb_en;
    logic                          mem_r_en;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{dest: '0, wb_en: 1'b0, mem_r_en: 1'b0};

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/sb_match.sv
// Source-vs-slot comparator: hit when a used source names a slot that writes back.
// Purely combinational, no backpressure.
module sb_match
  import pipeline_pkg::*;
(
  input  logic [REG_ADDR_W_DEFAULT-1:0] src,
  input  logic                          src_used,
  input  sb_entry_t                     entry,
  output logic                          hit
);

  assign hit = src_used && entry.wb_en && (entry.dest == src);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks EXE/MEM/WB destinations and raises a zero-latency stall on uncoverable RAW hazards.
// Slots advance each edge unless freeze holds them; optional stall_count under HAZARD_STALL_COUNT_EN.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src1,
  input  logic [REG_ADDR_W-1:0] id_src2,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_wb_en,
  input  logic                  id_mem_r_en,
  input  logic                  forwarding_mode,
  input  logic                  freeze,
  input  logic                  flush,
  output logic                  hazard_stall,
  output logic [REG_ADDR_W-1:0] exe_dest,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  exe_wb_en,
  output logic                  mem_wb_en,
  output logic                  wb_wb_en,
  output logic                  exe_mem_r_en
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  sb_entry_t exe_q, mem_q, wb_q;
  sb_entry_t id_entry;
  logic      hit1_exe, hit2_exe, hit1_mem, hit2_mem;
  logic      stall_raw;
  logic      unused_bits;

  assign id_entry = '{dest: id_dest, wb_en: id_wb_en, mem_r_en: id_mem_r_en};

  sb_match u_m1_exe (.src(id_src1), .src_used(1'b1),       .entry(exe_q), .hit(hit1_exe));
  sb_match u_m2_exe (.src(id_src2), .src_used(id_two_src), .entry(exe_q), .hit(hit2_exe));
  sb_match u_m1_mem (.src(id_src1), .src_used(1'b1),       .entry(mem_q), .hit(hit1_mem));
  sb_match u_m2_mem (.src(id_src2), .src_used(id_two_src), .entry(mem_q), .hit(hit2_mem));

  // WB never stalls: the register file writes on the falling edge, ahead of ID's read.
  always_comb begin
    stall_raw = 1'b0;
    if (id_valid) begin
      if (forwarding_mode)
        stall_raw = (hit1_exe || hit2_exe) && exe_q.mem_r_en;
      else
        stall_raw = hit1_exe || hit2_exe || hit1_mem || hit2_mem;
    end
  end

  assign hazard_stall = stall_raw && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_q <= SB_BUBBLE;
      mem_q <= SB_BUBBLE;
      wb_q  <= SB_BUBBLE;
    end else if (!freeze) begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= (flush || hazard_stall || !id_valid) ? SB_BUBBLE : id_entry;
    end
  end

  assign exe_dest     = exe_q.dest;
  assign mem_dest     = mem_q.dest;
  assign wb_dest      = wb_q.dest;
  assign exe_wb_en    = exe_q.wb_en;
  assign mem_wb_en    = mem_q.wb_en;
  assign wb_wb_en     = wb_q.wb_en;
  assign exe_mem_r_en = exe_q.mem_r_en;
  assign unused_bits  = wb_q.mem_r_en;

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cnt_q;

  // Frozen cycles are not counted: the bubble is only injected when the pipe moves.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (hazard_stall && !freeze && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_count = stall_cnt_q;
`endif

endmodule
